delay_line_arbiter: RTL and testbench

Controller that shares one external shift-register delay line (depth size, width width, shift on enable) between two requesters, A and B. It arbitrates between them round-robin and drives the line's enable and input. It keeps a mirrored tag pipeline (valid + owner bit per stage), so each item leaving the line goes back to the requester that sent it, under ready/valid backpressure.

---
 rtl/delay_line_arbiter.sv | 58 +++++
 tb/tb_delay_line_arbiter.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/delay_line_arbiter.sv
// delay_line_arbiter: round-robin sharing of one external delay line between requesters A and B,
// with a tag pipeline mirroring the line so each emerging item is routed back to its owner.
module delay_line_arbiter #(
   parameter int size = 10,
   parameter int width = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       req_a,
   input  logic [width-1:0]           data_a,
   output logic                       ack_a,
   input  logic                       req_b,
   input  logic [width-1:0]           data_b,
   output logic                       ack_b,
   output logic [width-1:0]           dl_in,
   output logic                       dl_enable,
   input  logic [width-1:0]           dl_out,
   output logic                       resp_valid_a,
   input  logic                       resp_ready_a,
   output logic                       resp_valid_b,
   input  logic                       resp_ready_b,
   output logic [width-1:0]           resp_data,
   output logic [$clog2(size+1)-1:0]  occupancy
);
   localparam int ow = $clog2(size+1);
   logic [size-1:0] tag_valid, tag_id;
   logic favor_b, last_valid, last_id, stall, advance, gnt_a, gnt_b, gnt, hs;
   always_comb begin
      last_valid = tag_valid[size-1];
      last_id = tag_id[size-1];
      stall = last_valid && !(last_id ? resp_ready_b : resp_ready_a);
      advance = rst_n && !stall && (occupancy != '0 || req_a || req_b);
      gnt_a = advance && req_a && (!req_b || !favor_b);
      gnt_b = advance && req_b && !gnt_a;
      gnt = gnt_a || gnt_b;
      hs = rst_n && last_valid && !stall;
      ack_a = gnt_a;
      ack_b = gnt_b;
      dl_enable = advance;
      dl_in = gnt_a ? data_a : gnt_b ? data_b : '0;
      resp_valid_a = rst_n && last_valid && !last_id;
      resp_valid_b = rst_n && last_valid && last_id;
      resp_data = dl_out;
   end
   // an exit and an entry on the same edge leave occupancy unchanged
   always_ff @(posedge clk)
      if (!rst_n) begin
         tag_valid <= '0;
         tag_id <= '0;
         occupancy <= '0;
         favor_b <= 1'b0;
      end else if (advance) begin
         tag_valid <= {tag_valid[size-2:0], gnt};
         tag_id <= {tag_id[size-2:0], gnt_b};
         occupancy <= occupancy + ow'(gnt) - ow'(hs);
         if (gnt) favor_b <= gnt_a;
      end
endmodule

// File: tb/tb_delay_line_arbiter.sv
// tb_delay_line_arbiter: random and directed stimulus against an item-queue model of the shared line.
module tb_delay_line_arbiter;
   localparam int SIZE = 10;
   localparam int W = 8;
   localparam int OW = $clog2(SIZE+1);

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic req_a = 1'b0, req_b = 1'b0, ack_a, ack_b;
   logic [W-1:0] data_a = '0, data_b = '0, dl_in, dl_out, resp_data;
   logic dl_enable, resp_valid_a, resp_valid_b;
   logic resp_ready_a = 1'b1, resp_ready_b = 1'b1;
   logic [OW-1:0] occupancy;

   always #5 clk = ~clk;

   delay_line_arbiter #(.size(SIZE), .width(W)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_a(req_a), .data_a(data_a), .ack_a(ack_a),
      .req_b(req_b), .data_b(data_b), .ack_b(ack_b),
      .dl_in(dl_in), .dl_enable(dl_enable), .dl_out(dl_out),
      .resp_valid_a(resp_valid_a), .resp_ready_a(resp_ready_a),
      .resp_valid_b(resp_valid_b), .resp_ready_b(resp_ready_b),
      .resp_data(resp_data), .occupancy(occupancy)
   );

   // the external line: plain shift register, no reset
   logic [W-1:0] line [SIZE];
   always @(posedge clk)
      if (dl_enable) begin
         line[0] <= dl_in;
         for (int i = 1; i < SIZE; i++) line[i] <= line[i-1];
      end
   assign dl_out = line[SIZE-1];

   int n_cmp = 0, n_bad = 0;
   bit armed = 0;
   bit sa, sb;

   function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endfunction

   // model: in-flight items in order, each knowing how many shifts it has taken
   typedef struct {bit id; logic [W-1:0] d; int pos;} item_t;
   item_t q[$];
   bit last_b = 1;

   function automatic void model_step();
      bit front, own, rdy, stall, adv, ga, gb, hs;
      logic [W-1:0] din;
      front = q.size() > 0 && q[0].pos == SIZE-1;
      own = front ? q[0].id : 1'b0;
      rdy = own ? resp_ready_b : resp_ready_a;
      stall = front && !rdy;
      adv = rst_n && !stall && (q.size() > 0 || req_a || req_b);
      ga = adv && req_a && (!req_b || last_b);
      gb = adv && req_b && !ga;
      hs = rst_n && front && rdy;
      din = ga ? data_a : gb ? data_b : '0;
      if (armed) begin
         cmp("ack_a", 32'(ack_a), 32'(ga));
         cmp("ack_b", 32'(ack_b), 32'(gb));
         cmp("dl_enable", 32'(dl_enable), 32'(adv));
         cmp("resp_valid_a", 32'(resp_valid_a), 32'(rst_n && front && !own));
         cmp("resp_valid_b", 32'(resp_valid_b), 32'(rst_n && front && own));
         cmp("occupancy", 32'(occupancy), 32'(q.size()));
         if (adv) cmp("dl_in", 32'(dl_in), 32'(din));
         if (rst_n && front) cmp("resp_data", 32'(resp_data), 32'(q[0].d));
      end
      if (!rst_n) begin
         q.delete();
         last_b = 1;
      end else if (adv) begin
         if (hs) void'(q.pop_front());
         foreach (q[i]) q[i].pos++;
         if (ga || gb) begin
            q.push_back('{gb, din, 0});
            last_b = gb;
         end
      end
   endfunction

   task automatic cyc();
      @(negedge clk);
      model_step();
      sa = ack_a;
      sb = ack_b;
   endtask

   task automatic nxt();
      @(posedge clk);
      armed = 1;
      #1;
   endtask

   task automatic do_reset(int n);
      rst_n = 0;
      req_a = 0;
      req_b = 0;
      repeat (n) begin cyc(); nxt(); end
      rst_n = 1;
   endtask

   logic [W-1:0] exp3 [6] = '{8'd1, 8'd101, 8'd2, 8'd102, 8'd3, 8'd103};

   initial begin
      // idle after reset
      do_reset(3);
      for (int k = 0; k < 20; k++) begin
         cyc();
         if (k % 5 == 0) begin
            cmp("idle_en", 32'(dl_enable), 0);
            cmp("idle_occ", 32'(occupancy), 0);
         end
         nxt();
      end
      // single item
      req_a = 1; data_a = 8'h11;
      for (int k = 0; k <= 11; k++) begin
         cyc();
         if (k == 0) cmp("single_ack", 32'(ack_a), 1);
         else cmp("single_occ", 32'(occupancy), (k <= 10) ? 1 : 0);
         cmp("single_rva", 32'(resp_valid_a), 32'(k == 10));
         if (k == 10) cmp("single_data", 32'(resp_data), 32'h11);
         if (k == 11) cmp("single_en_off", 32'(dl_enable), 0);
         nxt();
         if (k == 0) req_a = 0;
      end
      // contention
      do_reset(1);
      req_a = 1; req_b = 1; data_a = 8'd1; data_b = 8'd101;
      for (int k = 0; k < 16; k++) begin
         cyc();
         if (k < 6) begin
            cmp("rr_ack_a", 32'(ack_a), 32'(k % 2 == 0));
            cmp("rr_ack_b", 32'(ack_b), 32'(k % 2 == 1));
         end
         if (k >= 10) begin
            cmp("rr_data", 32'(resp_data), 32'(exp3[k-10]));
            cmp("rr_rvb", 32'(resp_valid_b), 32'(k % 2 == 1));
         end
         nxt();
         if (sa) begin if (data_a == 8'd3) req_a = 0; else data_a++; end
         if (sb) begin if (data_b == 8'd103) req_b = 0; else data_b++; end
      end
      // backpressure
      do_reset(1);
      resp_ready_a = 0; req_a = 1; data_a = 8'h22;
      for (int k = 0; k <= 26; k++) begin
         if (k == 10) begin req_b = 1; data_b = 8'h33; end
         if (k == 15) resp_ready_a = 1;
         cyc();
         if (k == 0) cmp("bp_ack_a", 32'(ack_a), 1);
         if (k >= 10 && k <= 14) begin
            cmp("bp_rva", 32'(resp_valid_a), 1);
            cmp("bp_data", 32'(resp_data), 32'h22);
            cmp("bp_en", 32'(dl_enable), 0);
            cmp("bp_ack_b", 32'(ack_b), 0);
         end
         if (k == 15) cmp("bp_release_ack_b", 32'(ack_b), 1);
         if (k == 25) begin
            cmp("bp_rvb", 32'(resp_valid_b), 1);
            cmp("bp_data_b", 32'(resp_data), 32'h33);
         end
         nxt();
         if (k == 0) req_a = 0;
         if (k == 15) req_b = 0;
      end
      // spacing
      do_reset(1);
      for (int k = 0; k < 16; k++) begin
         if (k == 0) begin req_a = 1; data_a = 8'h05; end
         if (k == 3) begin req_b = 1; data_b = 8'h07; end
         cyc();
         cmp("sp_rva", 32'(resp_valid_a), 32'(k == 10));
         cmp("sp_rvb", 32'(resp_valid_b), 32'(k == 13));
         nxt();
         if (k == 0) req_a = 0;
         if (k == 3) req_b = 0;
      end
      // reset mid-flight
      do_reset(1);
      req_a = 1; data_a = 8'h40;
      for (int k = 0; k < 5; k++) begin
         cyc(); nxt();
         if (k < 2) data_a++; else req_a = 0;
      end
      rst_n = 0;
      cyc(); nxt();
      rst_n = 1;
      for (int k = 0; k < 15; k++) begin
         cyc();
         if (k == 0) cmp("mid_occ", 32'(occupancy), 0);
         cmp("mid_rv", 32'({resp_valid_a, resp_valid_b}), 0);
         nxt();
      end
      req_a = 1; data_a = 8'h5A;
      cyc();
      cmp("mid_ack", 32'(ack_a), 1);
      nxt();
      req_a = 0;
      repeat (SIZE-1) begin cyc(); cmp("mid_early", 32'(resp_valid_a), 0); nxt(); end
      cyc();
      cmp("mid_rva", 32'(resp_valid_a), 1);
      cmp("mid_data", 32'(resp_data), 32'h5A);
      nxt();
      // random traffic
      for (int k = 0; k < 4000; k++) begin
         rst_n = ($urandom_range(0, 299) != 0);
         resp_ready_a = ($urandom_range(0, 3) != 0);
         resp_ready_b = ($urandom_range(0, 4) != 0);
         cyc();
         nxt();
         if (sa || !req_a) begin req_a = ($urandom_range(0, 2) != 0); data_a = W'($urandom); end
         if (sb || !req_b) begin req_b = ($urandom_range(0, 2) != 0); data_b = W'($urandom); end
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
